// File: rtl/toggle_seq.sv
// Pulse sequencer driving the T input of a downstream toggle stage: N pulses spaced by a period.
// Define TGEN_QTRACK_EN to build the q_exp tracker that predicts the downstream Q.
module toggle_seq #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic [CW-1:0] period,
  input  logic          abort,
  output logic          T,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] remaining,
  output logic          q_exp
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic          t_q, t_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [CW-1:0] peff_q, peff_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      t_q     <= 1'b0;
      rem_q   <= '0;
      timer_q <= '0;
      peff_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      rem_q   <= rem_d;
      timer_q <= timer_d;
      peff_q  <= peff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = 1'b0;
    rem_d   = rem_q;
    timer_d = timer_q;
    peff_d  = peff_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          peff_d  = (period == '0) ? CW'(1) : period;
          rem_d   = count;
          timer_d = '0;
          state_d = (count == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // Abort outranks completion and pulse issue; remaining keeps its value.
        if (abort) begin
          state_d = StIdle;
        end else if (rem_q == '0 && timer_q == '0) begin
          state_d = StDone;
        end else if (timer_q == '0) begin
          t_d     = 1'b1;
          rem_d   = rem_q - CW'(1);
          timer_d = peff_q - CW'(1);
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign T         = t_q;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign remaining = rem_q;

`ifdef TGEN_QTRACK_EN
  logic q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 1'b0;
    end else if (t_q) begin
      q_q <= ~q_q;
    end
  end

  assign q_exp = q_q;
`else
  assign q_exp = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_seq.sv
// Randomized and directed bench for toggle_seq against a closed-form schedule model.
module tb_toggle_seq;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] count, period;
  logic       T, busy, done, q_exp;
  logic [7:0] remaining;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 idle, 1 run (k edges since acceptance), 2 done.
  int m_mode, m_n, m_p, m_k, m_hold, m_q;

  toggle_seq #(.CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .period    (period),
    .abort     (abort),
    .T         (T),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .q_exp     (q_exp)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_t();
    if (m_mode != 1) return 0;
    return (m_k >= 1 && m_k <= 1 + (m_n - 1) * m_p && (m_k - 1) % m_p == 0) ? 1 : 0;
  endfunction

  function automatic int exp_rem();
    int issued;
    if (m_mode == 0) return m_hold;
    if (m_mode == 2) return 0;
    if (m_k == 0) return m_n;
    issued = (m_k - 1) / m_p + 1;
    if (issued > m_n) issued = m_n;
    return m_n - issued;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_p = 1; m_k = 0; m_hold = 0; m_q = 0;
  endtask

  task automatic model_edge(input bit s, input bit a, input int c, input int p);
    if (exp_t() == 1) m_q ^= 1;
    case (m_mode)
      0: if (s && !a) begin
        m_n = c; m_p = (p == 0) ? 1 : p; m_k = 0; m_hold = c;
        m_mode = (c == 0) ? 2 : 1;
      end
      1: if (a) begin
        m_hold = exp_rem();
        m_mode = 0;
      end else begin
        m_k++;
        if (m_k == 1 + m_n * m_p) m_mode = 2;
      end
      default: begin
        m_mode = 0; m_hold = 0;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    int qe;
`ifdef TGEN_QTRACK_EN
    qe = m_q;
`else
    qe = 0;
`endif
    check_val({tag, ".T"}, T, exp_t());
    check_val({tag, ".busy"}, busy, (m_mode == 1) ? 1 : 0);
    check_val({tag, ".done"}, done, (m_mode == 2) ? 1 : 0);
    check_val({tag, ".rem"}, remaining, exp_rem());
    check_val({tag, ".q"}, q_exp, qe);
  endtask

  // Drive at negedge, model the posedge, check at the following negedge.
  task automatic cyc(input string tag, input bit s, input bit a, input int c, input int p);
    start = s; abort = a; count = c[7:0]; period = p[7:0];
    @(posedge clk);
    model_edge(s, a, c, p);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; count = '0; period = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    cyc("c3p4", 1, 0, 3, 4);
    for (int i = 0; i < 16; i++) cyc("c3p4", 0, 0, 0, 0);

    cyc("c4p0", 1, 0, 4, 0);
    for (int i = 0; i < 7; i++) cyc("c4p0", 0, 0, 0, 0);

    cyc("c0p5", 1, 0, 0, 5);
    for (int i = 0; i < 3; i++) cyc("c0p5", 0, 0, 0, 0);

    // Start held high through the run must be ignored; abort after the 2nd pulse.
    cyc("abort", 1, 0, 5, 2);
    for (int i = 0; i < 3; i++) cyc("abort", 1, 0, 7, 1);
    cyc("abort", 1, 1, 7, 1);
    check_val("abort.rem3", remaining, 3);
    for (int i = 0; i < 6; i++) cyc("abort", 0, 0, 0, 0);

    cyc("rstmid", 1, 0, 6, 3);
    for (int i = 0; i < 4; i++) cyc("rstmid", 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    check_val("rstmid.T", T, 0);
    check_val("rstmid.busy", busy, 0);
    check_val("rstmid.done", done, 0);
    check_val("rstmid.rem", remaining, 0);
    check_val("rstmid.q", q_exp, 0);
    model_reset();
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc("rstmid", 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) cyc("stab", 1, 1, 3, 3);
    cyc("c1p1", 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc("c1p1", 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
          $urandom_range(0, 6), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
